// File: rtl/corescore_rst_seq.sv
// Purpose : staged reset release for corescore core groups, driven by PLL lock.
// Latency : o_rst[0] falls 2+LOCK_FILTER+STAGE_CYCLES edges after i_locked is first sampled high.
// Backpressure : none; free-running sequencer, lock loss re-asserts every group reset.
//
// Ports:
//   i_clk            system clock (PLL output clock)
//   i_rst            synchronous active-high reset, overrides everything
//   i_locked         raw PLL lock, asynchronous to i_clk
//   o_rst            per-group reset, active high, thermometer code (bit 0 released first)
//   o_ready          high once every group is out of reset
//   o_lock_loss_cnt  saturating count of lock losses seen while releasing or running
//
// Optional feature: define CORESCORE_RST_SEQ_STICKY_EN to make a lock loss
// latch into a FAULT state that only i_rst can clear.

module corescore_rst_seq #(
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_CYCLES = 256,
  parameter int LOCK_FILTER  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_locked,
  output logic [NUM_STAGES-1:0] o_rst,
  output logic                  o_ready,
  output logic [7:0]            o_lock_loss_cnt
);

  // Counter widths, never narrower than one bit.
  localparam int TW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam int FW = (LOCK_FILTER  > 1) ? $clog2(LOCK_FILTER)  : 1;
  localparam int SW = (NUM_STAGES   > 1) ? $clog2(NUM_STAGES)   : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(STAGE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2
`ifdef CORESCORE_RST_SEQ_STICKY_EN
    ,
    ST_FAULT     = 2'd3
`endif
  } state_t;

  // Where a lock loss sends the sequencer.
`ifdef CORESCORE_RST_SEQ_STICKY_EN
  localparam state_t LOSS_STATE = ST_FAULT;
`else
  localparam state_t LOSS_STATE = ST_WAIT_LOCK;
`endif

  state_t        state;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] timer;
  logic [SW-1:0] stage;
  logic          locked_meta;
  logic          locked_s;
  logic          lock_lost;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous lock indication.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= i_locked;
      locked_s    <= locked_meta;
    end
  end

  // Losing lock only matters once sequencing has started; dropping out while
  // still filtering just restarts the filter.
  always_comb begin
    lock_lost = 1'b0;
    if (!locked_s && (state == ST_RELEASE || state == ST_RUN))
      lock_lost = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_WAIT_LOCK;
      filt_cnt        <= '0;
      timer           <= '0;
      stage           <= '0;
      o_rst           <= '1;
      o_ready         <= 1'b0;
      o_lock_loss_cnt <= 8'd0;
    end else if (lock_lost) begin
      // Takes priority over a stage release landing on the same cycle.
      state    <= LOSS_STATE;
      filt_cnt <= '0;
      timer    <= '0;
      stage    <= '0;
      o_rst    <= '1;
      o_ready  <= 1'b0;
      if (o_lock_loss_cnt != 8'hFF)
        o_lock_loss_cnt <= o_lock_loss_cnt + 8'd1;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          o_rst   <= '1;
          o_ready <= 1'b0;
          timer   <= '0;
          stage   <= '0;
          if (!locked_s) begin
            filt_cnt <= '0;
          end else if (filt_cnt == FILT_LAST) begin
            // Lock has been stable long enough; start the staged release.
            filt_cnt <= '0;
            state    <= ST_RELEASE;
          end else begin
            filt_cnt <= filt_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (timer == TIMER_LAST) begin
            timer        <= '0;
            // Clearing only the current bit keeps already-released groups
            // low, so o_rst stays a thermometer code.
            o_rst[stage] <= 1'b0;
            if (stage == STAGE_LAST) begin
              stage   <= '0;
              o_ready <= 1'b1;
              state   <= ST_RUN;
            end else begin
              stage <= stage + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_RUN: begin
          o_rst   <= '0;
          o_ready <= 1'b1;
        end

`ifdef CORESCORE_RST_SEQ_STICKY_EN
        ST_FAULT: begin
          // Held until i_rst regardless of what the PLL does.
          o_rst   <= '1;
          o_ready <= 1'b0;
        end
`endif

        default: begin
          state    <= ST_WAIT_LOCK;
          filt_cnt <= '0;
          timer    <= '0;
          stage    <= '0;
          o_rst    <= '1;
          o_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corescore_rst_seq.sv
// Purpose : directed self-checking bench for corescore_rst_seq at default parameters.
// Latency : checks exact edge counts of each stage release and of lock-loss response.
// Backpressure : n/a; inputs driven 1 time unit after each rising edge.

module tb_corescore_rst_seq;

  logic       i_clk;
  logic       i_rst;
  logic       i_locked;
  logic [3:0] o_rst;
  logic       o_ready;
  logic [7:0] o_lock_loss_cnt;

  int total;
  int bad;

  corescore_rst_seq dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_locked        (i_locked),
    .o_rst           (o_rst),
    .o_ready         (o_ready),
    .o_lock_loss_cnt (o_lock_loss_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    i_rst    = 1'b1;
    i_locked = 1'b0;

    // Reset state
    step(4);
    chk("rst_o_rst",   {28'd0, o_rst}, 32'hF);
    chk("rst_ready",   {31'd0, o_ready}, 32'd0);
    chk("rst_cnt",     {24'd0, o_lock_loss_cnt}, 32'd0);

    // Clean power-up sequence: first sampling edge is edge 1, bit 0 falls at edge 274
    i_rst    = 1'b0;
    i_locked = 1'b1;
    step(273);
    chk("up_pre_b0",   {28'd0, o_rst}, 32'hF);
    step(1);
    chk("up_b0",       {28'd0, o_rst}, 32'hE);
    step(255);
    chk("up_pre_b1",   {28'd0, o_rst}, 32'hE);
    step(1);
    chk("up_b1",       {28'd0, o_rst}, 32'hC);
    step(255);
    chk("up_pre_b2",   {28'd0, o_rst}, 32'hC);
    step(1);
    chk("up_b2",       {28'd0, o_rst}, 32'h8);
    step(255);
    chk("up_pre_b3",   {28'd0, o_rst}, 32'h8);
    chk("up_pre_rdy",  {31'd0, o_ready}, 32'd0);
    step(1);
    chk("up_b3",       {28'd0, o_rst}, 32'h0);
    chk("up_rdy",      {31'd0, o_ready}, 32'd1);
    chk("up_cnt",      {24'd0, o_lock_loss_cnt}, 32'd0);

    // One-cycle lock drop while running: reaction 3 edges after the low sample
    i_locked = 1'b0;
    step(1);
    i_locked = 1'b1;
    step(1);
    chk("run_drop_e2", {28'd0, o_rst}, 32'h0);
    step(1);
    chk("run_drop_rst", {28'd0, o_rst}, 32'hF);
    chk("run_drop_rdy", {31'd0, o_ready}, 32'd0);
    chk("run_drop_cnt", {24'd0, o_lock_loss_cnt}, 32'd1);
    // Re-sequence counted from the edge that re-sampled lock high
    step(271);
    chk("reseq_pre_b0", {28'd0, o_rst}, 32'hF);
    step(1);
    chk("reseq_b0",    {28'd0, o_rst}, 32'hE);
    step(256);
    chk("reseq_b1",    {28'd0, o_rst}, 32'hC);

    // Lock drop landing exactly on the stage-2 release cycle
    step(253);
    i_locked = 1'b0;
    step(1);
    i_locked = 1'b1;
    step(1);
    chk("mid_pre",     {28'd0, o_rst}, 32'hC);
    step(1);
    chk("mid_rst",     {28'd0, o_rst}, 32'hF);
    chk("mid_cnt",     {24'd0, o_lock_loss_cnt}, 32'd2);
    step(271);
    chk("mid_pre_b0",  {28'd0, o_rst}, 32'hF);
    step(1);
    chk("mid_b0",      {28'd0, o_rst}, 32'hE);
    step(256);
    chk("mid_b1",      {28'd0, o_rst}, 32'hC);

    // Synchronous reset mid-sequence
    i_rst = 1'b1;
    step(1);
    chk("srst_rst",    {28'd0, o_rst}, 32'hF);
    chk("srst_rdy",    {31'd0, o_ready}, 32'd0);
    chk("srst_cnt",    {24'd0, o_lock_loss_cnt}, 32'd0);

    // Glitch during filtering restarts the filter, no loss counted
    i_locked = 1'b0;
    step(1);
    i_rst    = 1'b0;
    i_locked = 1'b1;
    step(10);
    i_locked = 1'b0;
    step(1);
    i_locked = 1'b1;
    step(273);
    chk("glitch_pre_b0", {28'd0, o_rst}, 32'hF);
    step(1);
    chk("glitch_b0",   {28'd0, o_rst}, 32'hE);
    chk("glitch_cnt",  {24'd0, o_lock_loss_cnt}, 32'd0);

    // Saturation: each iteration re-enters RELEASE then loses lock once
    for (int i = 0; i < 254; i++) begin
      step(20);
      i_locked = 1'b0;
      step(1);
      i_locked = 1'b1;
    end
    step(3);
    chk("sat_254",     {24'd0, o_lock_loss_cnt}, 32'd254);
    for (int i = 0; i < 46; i++) begin
      step(20);
      i_locked = 1'b0;
      step(1);
      i_locked = 1'b1;
    end
    step(3);
    chk("sat_255",     {24'd0, o_lock_loss_cnt}, 32'd255);
    chk("sat_rst",     {28'd0, o_rst}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corescore_rst_seq.md
Name: corescore_rst_seq

Overview:
- Consumer-side counterpart to the PLL clock/reset generator.
- Takes the raw PLL lock indication and releases reset to NUM_STAGES core groups one stage at a time. This staggers the wake-up current surge across a large corescore array.
- Detects loss of lock, reasserts every stage reset, and counts lock-loss events for debug.

Parameters:
- NUM_STAGES, 4, number of independently released reset groups (1..16).
- STAGE_CYCLES, 256, clock cycles between consecutive stage releases (>=1).
- LOCK_FILTER, 16, consecutive synchronized-locked cycles required before sequencing starts (>=1).

Ports:
- i_clk  input  1  system clock (PLL output clock).
- i_rst  input  1  synchronous, active-high reset.
- i_locked  input  1  PLL lock; asynchronous to i_clk, synchronized internally.
- o_rst  output  NUM_STAGES  per-group reset, active high; bit 0 is released first.
- o_ready  output  1  high once all groups are out of reset.
- o_lock_loss_cnt  output  8  count of lock losses seen in RELEASE or RUN; saturates at 255.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high. No other reset input.
- Synchronizer: locked_s is i_locked through a 2-flop synchronizer, so it lags by 2 cycles. The synchronizer flops clear to 0 on i_rst.
- On i_rst:
  - o_rst all ones, o_ready=0, o_lock_loss_cnt=0.
  - Filter counter, stage timer and stage index all 0.
  - State WAIT_LOCK.
  - i_rst overrides everything, including mid-sequence.
- WAIT_LOCK:
  - o_rst all ones, o_ready=0.
  - Filter counter increments each cycle locked_s=1 and clears to 0 on any cycle locked_s=0.
  - When locked_s=1 and the filter counter equals LOCK_FILTER-1, go to RELEASE with timer=0 and stage=0.
- RELEASE:
  - Timer counts 0..STAGE_CYCLES-1.
  - On the cycle the timer equals STAGE_CYCLES-1: o_rst[stage] clears at the next edge, the timer wraps to 0, and stage increments.
  - When the last stage (NUM_STAGES-1) is released, go to RUN. o_ready rises on the same edge that o_rst[NUM_STAGES-1] falls.
  - Bits already cleared stay 0, so o_rst is always a thermometer code with released bits at the low end.
- RUN:
  - o_rst all zeros, o_ready=1.
  - Stays here while locked_s=1.
- Lock loss (locked_s=0 while in RELEASE or RUN):
  - At the next edge, o_rst goes all ones and o_ready goes 0.
  - The filter counter, timer and stage clear.
  - o_lock_loss_cnt increments, saturating at 255.
  - State goes to WAIT_LOCK.
  - Lock loss takes priority over a coincident stage release.
  - locked_s=0 in WAIT_LOCK does not count as a lock loss.
- Latency with defaults: first edge sampling i_locked=1 to the o_rst[0] fall is 2+LOCK_FILTER+STAGE_CYCLES = 274 cycles. Each later bit falls STAGE_CYCLES cycles after the previous one.
- Widths: the timer is clog2(STAGE_CYCLES) bits, minimum 1. The filter counter is clog2(LOCK_FILTER) bits, minimum 1. No counter may wrap except the timer at STAGE_CYCLES-1.

Optional Feature:
- Macro: CORESCORE_RST_SEQ_STICKY_EN.
- Defined:
  - Lock loss moves to a FAULT state instead of WAIT_LOCK.
  - FAULT holds o_rst all ones and o_ready=0 regardless of i_locked. Only i_rst exits FAULT.
  - o_lock_loss_cnt still increments once on entry.
- Undefined: no FAULT state; automatic re-sequencing as described in Behaviour.

Test Plan:
- Defaults; i_rst for 4 cycles, then i_locked=1 held -> o_rst=4'b1111 until 274 cycles after the first i_locked sample. Then 4'b1110, 4'b1100, 4'b1000 and 4'b0000 at 256-cycle intervals; o_ready=1 on the same edge as 4'b0000.
- Lock glitch during filtering: i_locked high 10 cycles, low 1 cycle, high again -> release timing restarts from the second rise; o_lock_loss_cnt stays 0.
- Lock drop in RUN: deassert i_locked for 1 cycle -> 3 cycles later o_rst=4'b1111, o_ready=0, o_lock_loss_cnt=1. Full re-sequence follows with 274/256-cycle timing.
- Lock drop mid-RELEASE on the exact cycle stage 2 would release -> o_rst returns to 4'b1111 (no 4'b1000 seen); count increments.
- Saturation: 300 lock drops -> o_lock_loss_cnt=255.
- i_rst asserted while o_rst=4'b1100 -> next edge o_rst=4'b1111, count 0. With CORESCORE_RST_SEQ_STICKY_EN: a lock drop in RUN holds 4'b1111 forever despite i_locked=1, until i_rst.
